// File: rtl/uart_frame_pkg.sv
// Shared framing constants for the localbus UART response link.
// Used by the response framer and by the receive-side deframer.
package uart_frame_pkg;

    localparam int FRAME_LEN = 10;
    localparam int CKS_IDX   = 9;

    localparam logic [7:0] DEF_HDR0 = 8'h55;
    localparam logic [7:0] DEF_HDR1 = 8'hAA;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_FIN  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        SEND = ST_SEND,
        WAIT = ST_WAIT,
        FIN  = ST_FIN
    } state_t;

endpackage

// File: rtl/uart_resp_framer.sv
// Response framer: one (cmd, addr, data) response in, a 10-byte frame
// HDR0 HDR1 cmd addr[15:8] addr[7:0] data[31:24..7:0] CKS out, one byte
// per tx_valid/tx_done handshake with the UART core.
// Ports: clk, rst (async, active-high); resp_valid/resp_ready/resp_cmd/
// resp_addr/resp_data (response side); tx_byte/tx_valid/tx_done (UART
// core side); frame_done, frame_err (status pulses).
// Optional: define UART_RESP_FRAMER_TIMEOUT_EN to abort a frame when a
// byte's tx_done does not arrive within TIMEOUT_CYC cycles.
import uart_frame_pkg::*;

module uart_resp_framer #(
    parameter logic [7:0]  HDR0        = DEF_HDR0,
    parameter logic [7:0]  HDR1        = DEF_HDR1,
    parameter int unsigned TIMEOUT_CYC = 2000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        resp_valid,
    output logic        resp_ready,
    input  logic [7:0]  resp_cmd,
    input  logic [15:0] resp_addr,
    input  logic [31:0] resp_data,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_done,
    output logic        frame_done,
    output logic        frame_err
);

    state_t      state;
    state_t      next;
    logic        armed;
    logic [3:0]  idx;
    logic [7:0]  cks;
    logic [7:0]  cmd_q;
    logic [15:0] addr_q;
    logic [31:0] data_q;
    logic        accept;
    logic        last;
    logic        advance;
    logic [3:0]  sel;
    logic [7:0]  sel_byte;

    // armed keeps resp_ready low until the first clock after reset release
    assign resp_ready = armed && (state == IDLE);
    assign accept     = resp_valid && resp_ready;
    assign last       = (idx == 4'(CKS_IDX));
    assign advance    = (state == WAIT) && tx_done && !last;
    assign tx_valid   = (state == SEND);
    assign frame_done = (state == FIN);

    // tx_byte is loaded on the edge that enters SEND, so the mux looks
    // one byte ahead: byte 0 on capture, idx+1 when advancing.
    assign sel = (state == IDLE) ? 4'd0 : idx + 4'd1;

    always_comb begin
        sel_byte = 8'h00;
        case (sel)
            4'd0:    sel_byte = HDR0;
            4'd1:    sel_byte = HDR1;
            4'd2:    sel_byte = cmd_q;
            4'd3:    sel_byte = addr_q[15:8];
            4'd4:    sel_byte = addr_q[7:0];
            4'd5:    sel_byte = data_q[31:24];
            4'd6:    sel_byte = data_q[23:16];
            4'd7:    sel_byte = data_q[15:8];
            4'd8:    sel_byte = data_q[7:0];
            4'd9:    sel_byte = cks;
            default: sel_byte = 8'h00;
        endcase
    end

`ifdef UART_RESP_FRAMER_TIMEOUT_EN
    logic [31:0] tmo_cnt;
    logic        tmo_hit;

    assign tmo_hit = (tmo_cnt >= 32'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state == SEND) begin
            tmo_cnt <= '0;
        end else if (state == WAIT) begin
            tmo_cnt <= tmo_cnt + 32'd1;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            armed <= 1'b0;
        end else begin
            state <= next;
            armed <= 1'b1;
        end
    end

    always_comb begin
        next      = state;
        frame_err = 1'b0;
        unique case (state)
            IDLE: if (accept) next = SEND;
            SEND: next = WAIT;
            WAIT: begin
                if (tx_done) next = last ? FIN : SEND;
`ifdef UART_RESP_FRAMER_TIMEOUT_EN
                else if (tmo_hit) begin
                    next      = IDLE;
                    frame_err = 1'b1;
                end
`endif
            end
            FIN:  next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx     <= '0;
            cks     <= '0;
            tx_byte <= '0;
            cmd_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (accept) begin
            cmd_q   <= resp_cmd;
            addr_q  <= resp_addr;
            data_q  <= resp_data;
            idx     <= '0;
            cks     <= '0;
            tx_byte <= sel_byte;
        end else if (advance) begin
            idx     <= idx + 4'd1;
            tx_byte <= sel_byte;
            // running sum over payload bytes 2..8 as they are issued
            if (sel >= 4'd2 && sel <= 4'd8) begin
                cks <= cks + sel_byte;
            end
        end
    end

endmodule

// File: tb/tb_uart_resp_framer.sv
// Bench for uart_resp_framer: models the UART core (tx_done a fixed
// number of cycles after each tx_valid) and checks the byte stream.
module tb_uart_resp_framer;

    localparam int LAT = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        resp_valid;
    logic        resp_ready;
    logic [7:0]  resp_cmd;
    logic [15:0] resp_addr;
    logic [31:0] resp_data;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_done;
    logic        frame_done;
    logic        frame_err;

    logic        model_done;
    logic        spur_done;
    logic        suppress;
    logic        busy;
    int          cnt;

    logic [7:0]  got[$];
    int          fd_cnt = 0;
    int          err_cnt = 0;

    int          nvec = 0;
    int          nerr = 0;

    typedef struct packed {
        logic [7:0]  cmd;
        logic [15:0] addr;
        logic [31:0] data;
        logic [79:0] frame;
    } vec_t;

    vec_t tbl[4];

    always #5 clk = ~clk;

    assign tx_done = model_done | spur_done;

    uart_resp_framer #(
        .TIMEOUT_CYC(100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_cmd   (resp_cmd),
        .resp_addr  (resp_addr),
        .resp_data  (resp_data),
        .tx_byte    (tx_byte),
        .tx_valid   (tx_valid),
        .tx_done    (tx_done),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy       <= 1'b0;
            cnt        <= 0;
            model_done <= 1'b0;
        end else begin
            model_done <= 1'b0;
            if (tx_valid) begin
                busy <= !suppress;
                cnt  <= 1;
            end else if (busy) begin
                if (cnt >= LAT) begin
                    busy       <= 1'b0;
                    model_done <= 1'b1;
                end else begin
                    cnt <= cnt + 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (tx_valid) got.push_back(tx_byte);
        if (frame_done) fd_cnt <= fd_cnt + 1;
        if (frame_err) err_cnt <= err_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] c, input logic [15:0] a,
                        input logic [31:0] d);
        @(negedge clk);
        resp_cmd   = c;
        resp_addr  = a;
        resp_data  = d;
        resp_valid = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (resp_ready) break;
            @(negedge clk);
        end
        check("send_ready", 32'(resp_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        resp_valid = 1'b0;
    endtask

    task automatic wait_frame(input int base);
        for (int i = 0; i < 3000; i++) begin
            if (fd_cnt > base) break;
            @(negedge clk);
        end
        check("frame_done_seen", 32'(fd_cnt > base), 32'd1);
    endtask

    task automatic wait_bytes(input int base, input int n);
        for (int i = 0; i < 3000; i++) begin
            if (got.size() - base >= n) break;
            @(negedge clk);
        end
    endtask

    task automatic check_frame(input string tag, input int b,
                               input logic [79:0] frame);
        logic [31:0] act;
        for (int i = 0; i < 10; i++) begin
            act = (b + i < got.size()) ? 32'(got[b + i]) : 32'hxxxxxxxx;
            check($sformatf("%s_b%0d", tag, i), act,
                  32'(frame[79 - 8 * i -: 8]));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int f;
        int e;
        logic pf;
        logic ok;

        tbl[0] = '{8'h01, 16'h1234, 32'hDEADBEEF, 80'h55AA011234DEADBEEF7F};
        tbl[1] = '{8'hFF, 16'hFFFF, 32'hFFFFFFFF, 80'h55AAFFFFFFFFFFFFFFF9};
        tbl[2] = '{8'h00, 16'h0000, 32'h00000000, 80'h55AA0000000000000000};
        tbl[3] = '{8'hA5, 16'h0102, 32'h03040506, 80'h55AAA5010203040506BA};

        rst        = 1'b1;
        resp_valid = 1'b0;
        resp_cmd   = '0;
        resp_addr  = '0;
        resp_data  = '0;
        spur_done  = 1'b0;
        suppress   = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(resp_ready), 32'd0);
        check("rst_tx_byte", 32'(tx_byte), 32'h00);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        rst = 1'b0;
        #1;
        check("ready_at_release", 32'(resp_ready), 32'd0);
        @(negedge clk);
        check("ready_after_release", 32'(resp_ready), 32'd1);

        // tx_done while idle must not start anything
        b = got.size();
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        repeat (5) @(negedge clk);
        check("spur_no_bytes", 32'(got.size() - b), 32'd0);
        check("spur_ready", 32'(resp_ready), 32'd1);

        for (int v = 0; v < 4; v++) begin
            b = got.size();
            f = fd_cnt;
            send(tbl[v].cmd, tbl[v].addr, tbl[v].data);
            wait_frame(f);
            check_frame($sformatf("vec%0d", v), b, tbl[v].frame);
            check($sformatf("vec%0d_count", v), 32'(got.size() - b), 32'd10);
            check($sformatf("vec%0d_fd", v), 32'(fd_cnt - f), 32'd1);
            check($sformatf("vec%0d_ready", v), 32'(resp_ready), 32'd1);
        end

        // input changes mid-frame must not leak into the frame
        b = got.size();
        f = fd_cnt;
        send(tbl[0].cmd, tbl[0].addr, tbl[0].data);
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    resp_valid = ~resp_valid;
                    resp_cmd   = 8'($urandom);
                    resp_addr  = 16'($urandom);
                    resp_data  = $urandom;
                end
                resp_valid = 1'b0;
            end
            wait_frame(f);
        join
        check_frame("toggle", b, tbl[0].frame);
        check("toggle_fd", 32'(fd_cnt - f), 32'd1);

        // back-to-back with resp_valid held high
        b = got.size();
        f = fd_cnt;
        @(negedge clk);
        resp_cmd   = tbl[1].cmd;
        resp_addr  = tbl[1].addr;
        resp_data  = tbl[1].data;
        resp_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (resp_ready) break;
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        resp_cmd  = tbl[2].cmd;
        resp_addr = tbl[2].addr;
        resp_data = tbl[2].data;
        pf = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            pf = frame_done;
            @(negedge clk);
            if (resp_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("b2b_ready", 32'(ok), 32'd1);
        check("b2b_fd_before_ready", 32'(pf), 32'd1);
        @(posedge clk);
        @(negedge clk);
        resp_valid = 1'b0;
        wait_frame(f + 1);
        check_frame("b2b_first", b, tbl[1].frame);
        check_frame("b2b_second", b + 10, tbl[2].frame);
        check("b2b_count", 32'(got.size() - b), 32'd20);
        check("b2b_fd", 32'(fd_cnt - f), 32'd2);

        // reset after byte 4 has been issued
        b = got.size();
        f = fd_cnt;
        send(tbl[3].cmd, tbl[3].addr, tbl[3].data);
        wait_bytes(b, 5);
        rst = 1'b1;
        #1;
        check("mid_rst_tx_byte", 32'(tx_byte), 32'h00);
        check("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
        check("mid_rst_ready", 32'(resp_ready), 32'd0);
        check("mid_rst_frame_done", 32'(frame_done), 32'd0);
        check("mid_rst_frame_err", 32'(frame_err), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        check("mid_rst_no_fd", 32'(fd_cnt - f), 32'd0);
        check("mid_rst_bytes", 32'(got.size() - b), 32'd5);
        b = got.size();
        f = fd_cnt;
        send(tbl[0].cmd, tbl[0].addr, tbl[0].data);
        wait_frame(f);
        check_frame("after_rst", b, tbl[0].frame);

`ifdef UART_RESP_FRAMER_TIMEOUT_EN
        // byte 3 never completes
        b = got.size();
        f = fd_cnt;
        e = err_cnt;
        send(tbl[0].cmd, tbl[0].addr, tbl[0].data);
        wait_bytes(b, 3);
        suppress = 1'b1;
        wait_bytes(b, 4);
        @(negedge clk);
        suppress = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (err_cnt > e) break;
            @(negedge clk);
        end
        check("tmo_err", 32'(err_cnt - e), 32'd1);
        check("tmo_ready", 32'(resp_ready), 32'd1);
        repeat (50) @(negedge clk);
        check("tmo_err_once", 32'(err_cnt - e), 32'd1);
        check("tmo_no_fd", 32'(fd_cnt - f), 32'd0);
        check("tmo_bytes", 32'(got.size() - b), 32'd4);
`else
        e = err_cnt;
        check("no_frame_err", 32'(e), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
